mem_rqst_scheduler: RTL and testbench
=====================================

Name: mem_rqst_scheduler

Overview:
- Sits directly upstream of memory_controller.
- Accepts core memory requests over a valid/ready handshake and buffers them in a FIFO.
- Issues them to the memory controller as single-cycle wr_en/rd_en pulses.
- Tracks outstanding transactions by address tag, matches rd_ret/wr_ret acks back to them, and returns responses to the core.

Parameters:
- ADDR_W, 16, address width; matches the memory controller address bus.
- DATA_W, 16, data width.
- QUEUE_DEPTH, 4, request FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 4, outstanding-table entries (reads plus writes in flight).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- rqst_valid  in  1  core request valid.
- rqst_ready  out  1  FIFO not full.
- rqst_we  in  1  1 = write, 0 = read.
- rqst_address  in  ADDR_W  request address.
- rqst_data  in  DATA_W  write data.
- rd_resp_valid  out  1  one-cycle read-response pulse.
- rd_resp_address  out  ADDR_W  address of the completed read.
- rd_resp_data  out  DATA_W  read data.
- wr_resp_valid  out  1  one-cycle write-completion pulse.
- wr_resp_address  out  ADDR_W  address of the completed write.
- err_unmatched  out  1  sticky: a return ack arrived with no matching entry.
- wr_en  out  1  to controller.
- wr_address  out  ADDR_W  to controller.
- wr_data  out  DATA_W  to controller.
- rd_en  out  1  to controller.
- rd_address  out  ADDR_W  to controller.
- wr_ret_ack  in  1  from controller.
- wr_ret_address  in  ADDR_W  from controller; tag = address.
- rd_ret_ack  in  1  from controller.
- rd_ret_address  in  ADDR_W  from controller; tag = address.
- rd_ret_data  in  DATA_W  from controller.

Behaviour:
- Reset (async, active-high):
  - All outputs 0 except rqst_ready, which is 1.
  - FIFO empty; outstanding table all invalid; err_unmatched cleared.
  - Any in-flight transactions are dropped; returns arriving after reset deassertion set err_unmatched.
- Enqueue:
  - A request is accepted on a posedge when rqst_valid && rqst_ready.
  - rqst_ready = !full, combinational from FIFO count.
  - Full with rqst_valid high: no accept; the core holds the request.
- Issue (IDLE/ISSUE per cycle; no multi-cycle FSM):
  - The FIFO head issues on a posedge when all hold: FIFO non-empty, a free table entry exists, and no valid table entry has the same address (same-address ordering hazard).
  - On issue: the head pops, a table entry is allocated {valid, is_wr, address}, and exactly one of wr_en/rd_en is registered high for exactly one cycle with its address (and wr_data for writes).
  - wr_en and rd_en are never high together; at most one issue per cycle.
  - Blocked head: no issue; younger requests do not bypass (strict in-order issue).
- Latency:
  - A request accepted at edge E0 into an empty FIFO with the table free drives rd_en/wr_en high in the cycle after edge E1.
  - Enqueue and issue in the same cycle are legal; the FIFO count is unchanged.
  - Full with a pop in the same cycle: rqst_ready remains the registered !full, so no accept that cycle.
- Return matching:
  - rd_ret_ack: CAM-match rd_ret_address against valid read entries. On a hit, the entry frees and rd_resp_* is registered next cycle for one cycle, carrying rd_ret_data.
  - wr_ret_ack: same, against write entries, driving wr_resp_*.
  - rd and wr acks in the same cycle are both handled; both responses pulse together.
  - A miss sets err_unmatched (sticky until reset); table unchanged.
  - An entry freed and a new issue allocating in the same cycle are legal. The freed slot is usable that cycle; the hazard check uses the post-free table.
- Width rules:
  - FIFO pointers are log2(QUEUE_DEPTH) bits and wrap naturally; count is one bit wider.
  - Outstanding count is 0..MAX_OUTSTANDING.

Optional Feature:
- Macro MEM_RQST_STATS_EN.
- When defined: adds 32-bit output ports stat_rd_issued, stat_wr_issued and stat_stall_cycles.
  - stat_stall_cycles counts cycles in which the FIFO is non-empty but no issue occurs.
  - All three reset to 0 and wrap at 2^32.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W/DATA_W defaults.
  - typedef mem_rqst_t {we, address, data}.
  - typedef ost_entry_t {valid, is_wr, address}.
- One sub-module: mem_rqst_fifo, a parameterised synchronous FIFO with async reset exposing full/empty/count.
- Outstanding table and CAM stay in the top.

Test Plan:
- Single read: enqueue read 0x0010; controller returns rd_ret_ack with data 0xBEEF 3 cycles after rd_en -> rd_en pulses once with rd_address=0x0010; rd_resp_valid one cycle later with data 0xBEEF; table empty.
- FIFO full: hold issue blocked by 4 outstanding reads to distinct addresses, push 4 more -> rqst_ready=0 after the 4th; the 5th is held; it is accepted after the first rd_ret_ack frees an entry.
- Address hazard: write 0x0020 then read 0x0020 -> rd_en is not asserted until wr_ret_ack for 0x0020; the read then issues the next cycle.
- Simultaneous returns: reads 0x0001 and writes 0x0002 outstanding; both acks arrive in the same cycle -> rd_resp_valid and wr_resp_valid pulse together with the correct addresses.
- Unmatched ack: rd_ret_ack with address 0x7777, no entry -> err_unmatched=1, held until reset.
- Reset mid-operation: assert reset with 2 outstanding and 3 queued -> all outputs 0 immediately, rqst_ready=1; a later stale ack sets err_unmatched.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared widths, request/outstanding-entry types and the
//                outstanding-table tag compare used by the request scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // One queued core request
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] address;
    logic [DEF_DATA_W-1:0] data;
  } mem_rqst_t;

  // One in-flight transaction, tagged by its address
  typedef struct packed {
    logic                  valid;
    logic                  is_wr;
    logic [DEF_ADDR_W-1:0] address;
  } ost_entry_t;

  // CAM compare of a returning ack against one outstanding entry
  function automatic logic ost_hit(input ost_entry_t e, input logic is_wr,
                                   input logic [DEF_ADDR_W-1:0] address);
    return e.valid && (e.is_wr == is_wr) && (e.address == address);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rqst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rqst_fifo
//  Description : Parameterised synchronous FIFO, async active-high reset,
//                show-ahead head output, full/empty/count status.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_rqst_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; count is one bit wider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mem_rqst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rqst_scheduler
//  Description : Buffers core requests, issues them in order to the memory
//                controller as single-cycle pulses, tracks in-flight
//                transactions by address and matches returning acks.
//  Options     : MEM_RQST_STATS_EN adds issue/stall statistics counters.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_rqst_scheduler
  import mem_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,  // must equal the package width
  parameter int DATA_W          = DEF_DATA_W,  // must equal the package width
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rqst_valid,
  output logic              rqst_ready,
  input  logic              rqst_we,
  input  logic [ADDR_W-1:0] rqst_address,
  input  logic [DATA_W-1:0] rqst_data,
  output logic              rd_resp_valid,
  output logic [ADDR_W-1:0] rd_resp_address,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              wr_resp_valid,
  output logic [ADDR_W-1:0] wr_resp_address,
  output logic              err_unmatched,
`ifdef MEM_RQST_STATS_EN
  output logic [31:0]       stat_rd_issued,
  output logic [31:0]       stat_wr_issued,
  output logic [31:0]       stat_stall_cycles,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_address,
  input  logic              wr_ret_ack,
  input  logic [ADDR_W-1:0] wr_ret_address,
  input  logic              rd_ret_ack,
  input  logic [ADDR_W-1:0] rd_ret_address,
  input  logic [DATA_W-1:0] rd_ret_data
);

  localparam int FIFO_CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int IDX_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OST_CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  // ---------------- request FIFO ----------------
  mem_rqst_t               push_rqst;
  mem_rqst_t               head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic                    accept;
  logic                    issue;

  assign push_rqst  = '{we: rqst_we, address: rqst_address, data: rqst_data};
  // Ready follows the registered occupancy, so a pop in a full cycle does not
  // open the door until the next cycle
  assign rqst_ready = (fifo_count != FIFO_CNT_W'(QUEUE_DEPTH));
  assign accept     = rqst_valid && !fifo_full;

  mem_rqst_fifo #(
    .WIDTH ($bits(mem_rqst_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_rqst),
    .pop       (issue),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------- outstanding table ----------------
  ost_entry_t               ost [MAX_OUTSTANDING];
  logic [OST_CNT_W-1:0]     ost_count;
  logic [OST_CNT_W-1:0]     post_count;
  logic [MAX_OUTSTANDING-1:0] post_valid;
  logic                     rd_hit;
  logic                     wr_hit;
  logic [IDX_W-1:0]         rd_idx;
  logic [IDX_W-1:0]         wr_idx;
  logic [IDX_W-1:0]         free_idx;
  logic                     hazard;

  // CAM lookup of returning acks; the hazard check guarantees one match at most
  always_comb begin
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    rd_idx = '0;
    wr_idx = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (rd_ret_ack && !rd_hit && ost_hit(ost[i], 1'b0, rd_ret_address)) begin
        rd_hit = 1'b1;
        rd_idx = IDX_W'(i);
      end
      if (wr_ret_ack && !wr_hit && ost_hit(ost[i], 1'b1, wr_ret_address)) begin
        wr_hit = 1'b1;
        wr_idx = IDX_W'(i);
      end
    end
  end

  // Issue decision against the table as it will look after this cycle's frees
  always_comb begin
    logic found;
    found      = 1'b0;
    hazard     = 1'b0;
    free_idx   = '0;
    post_valid = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      post_valid[i] = ost[i].valid
                      && !(rd_hit && (rd_idx == IDX_W'(i)))
                      && !(wr_hit && (wr_idx == IDX_W'(i)));
      if (post_valid[i] && (ost[i].address == head.address)) hazard = 1'b1;
      if (!post_valid[i] && !found) begin
        found    = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign post_count = ost_count - OST_CNT_W'(rd_hit) - OST_CNT_W'(wr_hit);
  assign issue      = !fifo_empty && (post_count < OST_CNT_W'(MAX_OUTSTANDING)) && !hazard;

  // Table update: frees first, then the allocation may reuse a freed slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) ost[i] <= '0;
      ost_count <= '0;
    end else begin
      if (rd_hit) ost[rd_idx].valid <= 1'b0;
      if (wr_hit) ost[wr_idx].valid <= 1'b0;
      if (issue)  ost[free_idx] <= '{valid: 1'b1, is_wr: head.we, address: head.address};
      ost_count <= post_count + OST_CNT_W'(issue);
    end
  end

  // Controller-side issue pulses; address/data hold between issues
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      rd_address <= '0;
    end else begin
      wr_en <= issue && head.we;
      rd_en <= issue && !head.we;
      if (issue && head.we) begin
        wr_address <= head.address;
        wr_data    <= head.data;
      end
      if (issue && !head.we) rd_address <= head.address;
    end
  end

  // Core-side response pulses and the sticky unmatched-ack flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_resp_valid   <= 1'b0;
      rd_resp_address <= '0;
      rd_resp_data    <= '0;
      wr_resp_valid   <= 1'b0;
      wr_resp_address <= '0;
      err_unmatched   <= 1'b0;
    end else begin
      rd_resp_valid <= rd_hit;
      wr_resp_valid <= wr_hit;
      if (rd_hit) begin
        rd_resp_address <= rd_ret_address;
        rd_resp_data    <= rd_ret_data;
      end
      if (wr_hit) wr_resp_address <= wr_ret_address;
      err_unmatched <= err_unmatched || (rd_ret_ack && !rd_hit) || (wr_ret_ack && !wr_hit);
    end
  end

`ifdef MEM_RQST_STATS_EN
  // Free-running statistics; stall = work queued but nothing issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rd_issued    <= '0;
      stat_wr_issued    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (issue && !head.we)     stat_rd_issued    <= stat_rd_issued + 32'd1;
      if (issue && head.we)      stat_wr_issued    <= stat_wr_issued + 32'd1;
      if (!fifo_empty && !issue) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_rqst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_rqst_scheduler
//  Description : Directed and randomized self-checking bench for
//                mem_rqst_scheduler against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_rqst_scheduler;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int QD = 4;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rqst_valid = 1'b0;
  logic          rqst_ready;
  logic          rqst_we = 1'b0;
  logic [AW-1:0] rqst_address = '0;
  logic [DW-1:0] rqst_data = '0;
  logic          rd_resp_valid;
  logic [AW-1:0] rd_resp_address;
  logic [DW-1:0] rd_resp_data;
  logic          wr_resp_valid;
  logic [AW-1:0] wr_resp_address;
  logic          err_unmatched;
  logic          wr_en;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_address;
  logic          wr_ret_ack = 1'b0;
  logic [AW-1:0] wr_ret_address = '0;
  logic          rd_ret_ack = 1'b0;
  logic [AW-1:0] rd_ret_address = '0;
  logic [DW-1:0] rd_ret_data = '0;

  mem_rqst_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .rqst_valid(rqst_valid), .rqst_ready(rqst_ready), .rqst_we(rqst_we),
    .rqst_address(rqst_address), .rqst_data(rqst_data),
    .rd_resp_valid(rd_resp_valid), .rd_resp_address(rd_resp_address),
    .rd_resp_data(rd_resp_data),
    .wr_resp_valid(wr_resp_valid), .wr_resp_address(wr_resp_address),
    .err_unmatched(err_unmatched),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .rd_en(rd_en), .rd_address(rd_address),
    .wr_ret_ack(wr_ret_ack), .wr_ret_address(wr_ret_address),
    .rd_ret_ack(rd_ret_ack), .rd_ret_address(rd_ret_address),
    .rd_ret_data(rd_ret_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t pend[$];      // accepted, not yet issued, in order
  req_t inflight[$];  // issued, awaiting ack

  logic          e_rd_en, e_wr_en, e_rd_resp_v, e_wr_resp_v, e_err;
  logic [AW-1:0] e_rd_a, e_wr_a, e_rd_resp_a, e_wr_resp_a;
  logic [DW-1:0] e_wr_d, e_rd_resp_d;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int find_inflight(input logic we, input logic [AW-1:0] a);
    foreach (inflight[i]) if (inflight[i].we == we && inflight[i].addr == a) return i;
    return -1;
  endfunction

  function automatic bit addr_busy(input logic [AW-1:0] a);
    foreach (inflight[i]) if (inflight[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  // What one clock edge should do, given the inputs currently driven
  task automatic model_step();
    int   k;
    bit   room;
    req_t r;
    room = (pend.size() < QD);
    e_rd_resp_v = 1'b0;
    e_wr_resp_v = 1'b0;
    if (rd_ret_ack) begin
      k = find_inflight(1'b0, rd_ret_address);
      if (k >= 0) begin
        inflight.delete(k);
        e_rd_resp_v = 1'b1; e_rd_resp_a = rd_ret_address; e_rd_resp_d = rd_ret_data;
      end else e_err = 1'b1;
    end
    if (wr_ret_ack) begin
      k = find_inflight(1'b1, wr_ret_address);
      if (k >= 0) begin
        inflight.delete(k);
        e_wr_resp_v = 1'b1; e_wr_resp_a = wr_ret_address;
      end else e_err = 1'b1;
    end
    e_rd_en = 1'b0;
    e_wr_en = 1'b0;
    if (pend.size() > 0 && inflight.size() < MO && !addr_busy(pend[0].addr)) begin
      r = pend.pop_front();
      inflight.push_back(r);
      if (r.we) begin e_wr_en = 1'b1; e_wr_a = r.addr; e_wr_d = r.data; end
      else begin e_rd_en = 1'b1; e_rd_a = r.addr; end
    end
    if (rqst_valid && room) pend.push_back('{we: rqst_we, addr: rqst_address, data: rqst_data});
  endtask

  // One clock: check ready, advance model, clock, check registered outputs
  task automatic step();
    chk("rqst_ready", {31'd0, rqst_ready}, {31'd0, pend.size() < QD});
    model_step();
    @(posedge clk); #1;
    chk("rd_en", {31'd0, rd_en}, {31'd0, e_rd_en});
    chk("wr_en", {31'd0, wr_en}, {31'd0, e_wr_en});
    if (e_rd_en) chk("rd_address", {16'd0, rd_address}, {16'd0, e_rd_a});
    if (e_wr_en) begin
      chk("wr_address", {16'd0, wr_address}, {16'd0, e_wr_a});
      chk("wr_data", {16'd0, wr_data}, {16'd0, e_wr_d});
    end
    chk("rd_resp_valid", {31'd0, rd_resp_valid}, {31'd0, e_rd_resp_v});
    chk("wr_resp_valid", {31'd0, wr_resp_valid}, {31'd0, e_wr_resp_v});
    if (e_rd_resp_v) begin
      chk("rd_resp_address", {16'd0, rd_resp_address}, {16'd0, e_rd_resp_a});
      chk("rd_resp_data", {16'd0, rd_resp_data}, {16'd0, e_rd_resp_d});
    end
    if (e_wr_resp_v) chk("wr_resp_address", {16'd0, wr_resp_address}, {16'd0, e_wr_resp_a});
    chk("err_unmatched", {31'd0, err_unmatched}, {31'd0, e_err});
    rqst_valid = 1'b0;
    rd_ret_ack = 1'b0;
    wr_ret_ack = 1'b0;
  endtask

  // Async reset applied mid-cycle: outputs must clear without a clock edge
  task automatic do_reset();
    reset = 1'b1;
    #1;
    pend.delete();
    inflight.delete();
    e_err = 1'b0;
    chk("rst_rqst_ready", {31'd0, rqst_ready}, 32'd1);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_rd_address", {16'd0, rd_address}, 32'd0);
    chk("rst_wr_address", {16'd0, wr_address}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst_rd_resp_valid", {31'd0, rd_resp_valid}, 32'd0);
    chk("rst_rd_resp_address", {16'd0, rd_resp_address}, 32'd0);
    chk("rst_rd_resp_data", {16'd0, rd_resp_data}, 32'd0);
    chk("rst_wr_resp_valid", {31'd0, wr_resp_valid}, 32'd0);
    chk("rst_wr_resp_address", {16'd0, wr_resp_address}, 32'd0);
    chk("rst_err_unmatched", {31'd0, err_unmatched}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rqst_valid = 1'b1; rqst_we = we; rqst_address = a; rqst_data = d;
    step();
  endtask

  task automatic ack_rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_ret_ack = 1'b1; rd_ret_address = a; rd_ret_data = d;
    step();
  endtask

  task automatic ack_wr(input logic [AW-1:0] a);
    wr_ret_ack = 1'b1; wr_ret_address = a;
    step();
  endtask

  initial begin
    int rd_list[$];
    int wr_list[$];
    int pick;

    // ---- single read ----
    #2;
    do_reset();
    push(1'b0, 16'h0010, 16'h0);
    step();
    chk("single_rd_en", {31'd0, rd_en}, 32'd1);
    chk("single_rd_address", {16'd0, rd_address}, 32'h0010);
    step();
    step();
    ack_rd(16'h0010, 16'hBEEF);
    chk("single_rd_resp_valid", {31'd0, rd_resp_valid}, 32'd1);
    chk("single_rd_resp_data", {16'd0, rd_resp_data}, 32'hBEEF);
    step();

    // ---- FIFO full behind a full outstanding table ----
    do_reset();
    for (int i = 0; i < 4; i++) push(1'b0, 16'h0100 + 16'(i), 16'h0);
    for (int i = 0; i < 4; i++) push(1'b0, 16'h0200 + 16'(i), 16'h0);
    chk("full_ready_low", {31'd0, rqst_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      rqst_valid = 1'b1; rqst_we = 1'b0; rqst_address = 16'h0204; rqst_data = '0;
      step();
    end
    rqst_valid = 1'b1; rqst_we = 1'b0; rqst_address = 16'h0204;
    ack_rd(16'h0100, 16'h1111);
    chk("full_pop_no_accept_ready", {31'd0, rqst_ready}, 32'd1);
    push(1'b0, 16'h0204, 16'h0);
    chk("full_ready_again_low", {31'd0, rqst_ready}, 32'd0);

    // ---- same-address hazard ----
    do_reset();
    push(1'b1, 16'h0020, 16'hAAAA);
    push(1'b0, 16'h0020, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hazard_rd_blocked", {31'd0, rd_en}, 32'd0);
    end
    ack_wr(16'h0020);
    chk("hazard_rd_issue", {31'd0, rd_en}, 32'd1);
    chk("hazard_rd_address", {16'd0, rd_address}, 32'h0020);
    step();

    // ---- simultaneous returns ----
    do_reset();
    push(1'b0, 16'h0001, 16'h0);
    push(1'b1, 16'h0002, 16'h5555);
    step();
    step();
    rd_ret_ack = 1'b1; rd_ret_address = 16'h0001; rd_ret_data = 16'h1234;
    ack_wr(16'h0002);
    chk("simul_rd_valid", {31'd0, rd_resp_valid}, 32'd1);
    chk("simul_wr_valid", {31'd0, wr_resp_valid}, 32'd1);
    chk("simul_wr_address", {16'd0, wr_resp_address}, 32'h0002);

    // ---- unmatched ack ----
    ack_rd(16'h7777, 16'h0);
    chk("unmatched_err", {31'd0, err_unmatched}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("unmatched_sticky", {31'd0, err_unmatched}, 32'd1);

    // ---- reset mid-operation: 2 outstanding, 3 queued ----
    do_reset();
    push(1'b0, 16'h0300, 16'h0);
    push(1'b0, 16'h0301, 16'h0);
    push(1'b0, 16'h0300, 16'h0);
    push(1'b0, 16'h0302, 16'h0);
    push(1'b0, 16'h0303, 16'h0);
    do_reset();
    ack_rd(16'h0300, 16'h0);
    chk("stale_ack_err", {31'd0, err_unmatched}, 32'd1);

    // ---- randomized traffic ----
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rqst_valid   = ($urandom_range(0, 99) < 60);
      rqst_we      = 1'($urandom_range(0, 1));
      rqst_address = 16'($urandom_range(0, 7));
      rqst_data    = 16'($urandom);
      rd_list.delete();
      wr_list.delete();
      foreach (inflight[i]) begin
        if (inflight[i].we) wr_list.push_back(i);
        else rd_list.push_back(i);
      end
      if (rd_list.size() > 0 && $urandom_range(0, 99) < 40) begin
        pick = rd_list[$urandom_range(0, rd_list.size() - 1)];
        rd_ret_ack = 1'b1; rd_ret_address = inflight[pick].addr; rd_ret_data = 16'($urandom);
      end
      if (wr_list.size() > 0 && $urandom_range(0, 99) < 40) begin
        pick = wr_list[$urandom_range(0, wr_list.size() - 1)];
        wr_ret_ack = 1'b1; wr_ret_address = inflight[pick].addr;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
